// File: rtl/timer_pkg.sv
// timer_pkg: constants and types shared by the 8-bit timer channel blocks.
//   CNT_W       - counter and capture width
//   NUM_EV      - number of channel events (flag/intr/trigger bit count)
//   EV_*        - event bit indices: rise capture, fall capture, measurement done
//   cap_state_t - states of the period/high-time measurement FSM
package timer_pkg;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_EV = 3;

    localparam int unsigned EV_RISE = 0;
    localparam int unsigned EV_FALL = 1;
    localparam int unsigned EV_MEAS = 2;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } cap_state_t;

endpackage

// File: rtl/capture_filter.sv
// capture_filter: level stability filter for the capture input.
// The output follows the input only after the input has held a new level
// for FILTER_LEN consecutive clock cycles; shorter glitches are dropped.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   d        - synchronised input level
//   q        - filtered level (resets to 0)
module capture_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] cnt;

    // Count consecutive cycles of disagreement; restart on any agreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (d == q) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            cnt <= '0;
            q   <= d;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/input_capture.sv
// input_capture: input-capture and PWM-measurement channel for the 8-bit timer.
// Synchronises timer_in, latches counter_value on rising/falling edges and,
// in PWM mode, continuously measures period and high time.
// Optional feature macro: CAPTURE_FILTER_EN inserts capture_filter after the
// synchroniser (adds FILTER_LEN cycles of latency).
// Ports:
//   clk, rst              - timer clock, synchronous active-high reset
//   en                    - channel enable (low: no captures, FSM held in IDLE)
//   counter_value         - free-running timer count
//   timer_in, inv         - external waveform (async) and its polarity select
//   pwm_mode              - enables the period/high-time measurement FSM
//   intr_en, trg_en       - per-event interrupt / trigger enables
//   flag_clr              - write-1-to-clear pulses for flag and ovf
//   cap_rise, cap_fall    - counter_value at the last rising / falling edge
//   period, high_time     - last measured rise-to-rise / rise-to-fall interval
//   flag, ovf             - sticky event flags and capture overrun
//   intr                  - flag & intr_en (combinational)
//   trigger               - one-cycle pulse on any trigger-enabled event
module input_capture #(
    parameter int unsigned CNT_W      = timer_pkg::CNT_W,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [CNT_W-1:0]              counter_value,
    input  logic                          timer_in,
    input  logic                          inv,
    input  logic                          pwm_mode,
    input  logic [timer_pkg::NUM_EV-1:0]  intr_en,
    input  logic [timer_pkg::NUM_EV-1:0]  trg_en,
    input  logic [timer_pkg::NUM_EV-1:0]  flag_clr,
    output logic [CNT_W-1:0]              cap_rise,
    output logic [CNT_W-1:0]              cap_fall,
    output logic [CNT_W-1:0]              period,
    output logic [CNT_W-1:0]              high_time,
    output logic [timer_pkg::NUM_EV-1:0]  flag,
    output logic [1:0]                    ovf,
    output logic [timer_pkg::NUM_EV-1:0]  intr,
    output logic                          trigger
);

    import timer_pkg::*;

    logic              sync1;
    logic              sync2;
    logic              filt;
    logic              lvl;
    logic              lvl_d;
    logic [1:0]        warm;
    logic              edge_ok_c;
    logic              rise_c;
    logic              fall_c;
    logic [NUM_EV-1:0] ev_c;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic              ld_start_c;
    logic              ld_ht_c;
    logic              meas_done_c;
    logic [CNT_W-1:0]  start;
    logic [CNT_W-1:0]  ht_tmp;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= timer_in;
            sync2 <= sync1;
        end
    end

`ifdef CAPTURE_FILTER_EN
    capture_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk (clk),
        .rst (rst),
        .d   (sync2),
        .q   (filt)
    );
`else
    assign filt = sync2;

    // FILTER_LEN has no effect without the filter.
    if (FILTER_LEN == 0) begin : g_filter_len_unused
    end
`endif

    // Level register, its delayed copy, and the post-reset warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            warm  <= '0;
        end else begin
            lvl   <= filt ^ inv;
            lvl_d <= lvl;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    // Reset values of lvl/lvl_d must never look like an edge.
    assign edge_ok_c = (warm == 2'd3);
    assign rise_c    = edge_ok_c & lvl & ~lvl_d;
    assign fall_c    = edge_ok_c & ~lvl & lvl_d;

    assign ev_c[EV_RISE] = rise_c & en;
    assign ev_c[EV_FALL] = fall_c & en;
    assign ev_c[EV_MEAS] = meas_done_c;

    // Measurement FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Measurement FSM next state and datapath load strobes.
    always_comb begin
        state_d     = state_q;
        ld_start_c  = 1'b0;
        ld_ht_c     = 1'b0;
        meas_done_c = 1'b0;
        if (!en || !pwm_mode) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise_c) begin
                        ld_start_c = 1'b1;
                        state_d    = HIGH;
                    end
                end
                HIGH: begin
                    if (fall_c) begin
                        ld_ht_c = 1'b1;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    if (rise_c) begin
                        ld_start_c  = 1'b1;
                        meas_done_c = 1'b1;
                        state_d     = HIGH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Measurement datapath; wrap-around subtraction handles counter rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            start     <= '0;
            ht_tmp    <= '0;
            period    <= '0;
            high_time <= '0;
        end else begin
            if (ld_start_c) begin
                start <= counter_value;
            end
            if (ld_ht_c) begin
                ht_tmp <= counter_value - start;
            end
            if (meas_done_c) begin
                period    <= counter_value - start;
                high_time <= ht_tmp;
            end
        end
    end

    // Capture registers, sticky flags, overrun and trigger pulse.
    // An event beats a coincident clear; a clear always drops overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_rise <= '0;
            cap_fall <= '0;
            flag     <= '0;
            ovf      <= '0;
            trigger  <= 1'b0;
        end else begin
            if (ev_c[EV_RISE]) begin
                cap_rise <= counter_value;
            end
            if (ev_c[EV_FALL]) begin
                cap_fall <= counter_value;
            end
            for (int i = 0; i < int'(NUM_EV); i++) begin
                if (ev_c[i]) begin
                    flag[i] <= 1'b1;
                end else if (flag_clr[i]) begin
                    flag[i] <= 1'b0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (flag_clr[i]) begin
                    ovf[i] <= 1'b0;
                end else if (ev_c[i] && flag[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
            trigger <= |(ev_c & trg_en);
        end
    end

    assign intr = flag & intr_en;

endmodule

// File: tb/tb_input_capture.sv
// tb_input_capture: self-checking bench for input_capture.
// Captures are predicted when timer_in is driven (scoreboard queue) and
// checked when the DUT pulses trigger; flag/overrun priority is table-driven;
// PWM measurement, abort and filter cases are hand-written sequences.
module tb_input_capture;

    localparam int unsigned W = 8;
`ifdef CAPTURE_FILTER_EN
    localparam int unsigned LAT = 7;
`else
    localparam int unsigned LAT = 3;
`endif

    logic         clk;
    logic         rst;
    logic         en;
    logic [W-1:0] counter_value;
    logic         timer_in;
    logic         inv;
    logic         pwm_mode;
    logic [2:0]   intr_en;
    logic [2:0]   trg_en;
    logic [2:0]   flag_clr;
    logic [W-1:0] cap_rise;
    logic [W-1:0] cap_fall;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic [2:0]   flag;
    logic [1:0]   ovf;
    logic [2:0]   intr;
    logic         trigger;

    input_capture #(
        .CNT_W      (W),
        .FILTER_LEN (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .counter_value (counter_value),
        .timer_in      (timer_in),
        .inv           (inv),
        .pwm_mode      (pwm_mode),
        .intr_en       (intr_en),
        .trg_en        (trg_en),
        .flag_clr      (flag_clr),
        .cap_rise      (cap_rise),
        .cap_fall      (cap_fall),
        .period        (period),
        .high_time     (high_time),
        .flag          (flag),
        .ovf           (ovf),
        .intr          (intr),
        .trigger       (trigger)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running timer count.
    always @(posedge clk) begin
        if (rst) counter_value <= '0;
        else     counter_value <= counter_value + 8'd1;
    end

    typedef struct packed {
        logic         is_rise;
        logic [W-1:0] cap;
    } sb_item_t;

    typedef struct {
        bit         tog;
        logic [2:0] clr;
        logic [2:0] eflag;
        logic [1:0] eovf;
    } vec_t;

    sb_item_t sb_q[$];
    vec_t     vec[9];
    int       checks;
    int       errors;
    logic     cur_lvl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [W-1:0] pre(input logic [W-1:0] v);
        return W'(int'(v) - int'(LAT));
    endfunction

    task automatic wait_cnt(input logic [W-1:0] v);
        int k;
        k = 0;
        while (counter_value != v && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (counter_value != v) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt timeout actual=%0h required=%0h", counter_value, v);
        end
    endtask

    // Drive a level and predict the capture it will cause.
    task automatic drive_level(input logic v);
        sb_item_t it;
        if (v != cur_lvl) begin
            it.is_rise = v;
            it.cap     = W'(int'(counter_value) + int'(LAT));
            sb_q.push_back(it);
        end
        timer_in = v;
        cur_lvl  = v;
    endtask

    // Scoreboard monitor: every trigger pulse must match a predicted capture.
    always @(negedge clk) begin : mon
        sb_item_t it;
        if (!rst && trigger) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_trigger actual=1 required=0 (t=%0t)", $time);
            end else begin
                it = sb_q.pop_front();
                if (it.is_rise) chk("sb_cap_rise", int'(cap_rise), int'(it.cap));
                else            chk("sb_cap_fall", int'(cap_fall), int'(it.cap));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        vec[0] = '{1'b1, 3'b000, 3'b001, 2'b00};
        vec[1] = '{1'b1, 3'b000, 3'b011, 2'b00};
        vec[2] = '{1'b1, 3'b000, 3'b011, 2'b01};
        vec[3] = '{1'b0, 3'b010, 3'b001, 2'b01};
        vec[4] = '{1'b1, 3'b000, 3'b011, 2'b01};
        vec[5] = '{1'b1, 3'b001, 3'b011, 2'b00};
        vec[6] = '{1'b0, 3'b001, 3'b010, 2'b00};
        vec[7] = '{1'b1, 3'b000, 3'b010, 2'b10};
        vec[8] = '{1'b0, 3'b111, 3'b000, 2'b00};

        rst      = 1'b1;
        en       = 1'b1;
        inv      = 1'b1;
        timer_in = 1'b0;
        cur_lvl  = 1'b0;
        pwm_mode = 1'b0;
        intr_en  = 3'b111;
        trg_en   = 3'b011;
        flag_clr = 3'b000;
        tick(3);
        rst = 1'b0;

        // Reset and warm-up: inverted input must not look like an edge.
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("warm_flag", int'(flag), 0);
            chk("warm_trigger", int'(trigger), 0);
        end
        chk("rst_cap_rise", int'(cap_rise), 0);
        chk("rst_cap_fall", int'(cap_fall), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_intr", int'(intr), 0);

        // Changing inv while disabled produces no event.
        en = 1'b0;
        inv = 1'b0;
        tick(6);
        en = 1'b1;
        tick(2);
        chk("inv_flag", int'(flag), 0);

        // Single capture.
        intr_en = 3'b001;
        wait_cnt(8'h10);
        drive_level(1'b1);
        tick(LAT);
        chk("single_trig_before", int'(trigger), 0);
        tick(1);
        chk("single_cap_rise", int'(cap_rise), int'(W'(8'h10 + LAT)));
        chk("single_flag", int'(flag), 1);
        chk("single_intr", int'(intr), 1);
        chk("single_trig", int'(trigger), 1);
        tick(1);
        chk("single_trig_after", int'(trigger), 0);

        drive_level(1'b0);
        tick(LAT + 2);
        flag_clr = 3'b111;
        tick(1);
        flag_clr = 3'b000;
        chk("clr_all_flag", int'(flag), 0);
        chk("clr_all_ovf", int'(ovf), 0);

        // Flag / overrun / clear priority table.
        for (int i = 0; i < 9; i++) begin
            if (vec[i].tog) drive_level(~cur_lvl);
            tick(LAT);
            flag_clr = vec[i].clr;
            tick(1);
            flag_clr = 3'b000;
            chk($sformatf("vec%0d_flag", i), int'(flag), int'(vec[i].eflag));
            chk($sformatf("vec%0d_ovf", i), int'(ovf), int'(vec[i].eovf));
            tick(1);
        end

        // PWM measurement across a counter wrap.
        intr_en  = 3'b100;
        pwm_mode = 1'b1;
        tick(2);
        wait_cnt(pre(8'hF0)); drive_level(1'b1);
        wait_cnt(pre(8'h20)); drive_level(1'b0);
        wait_cnt(pre(8'h50)); drive_level(1'b1);
        wait_cnt(8'h50);
        chk("pwm1_period_before", int'(period), 0);
        chk("pwm1_meas_before", int'(flag[2]), 0);
        tick(1);
        chk("pwm1_period", int'(period), 8'h60);
        chk("pwm1_high_time", int'(high_time), 8'h30);
        chk("pwm1_meas_flag", int'(flag[2]), 1);
        chk("pwm1_intr", int'(intr[2]), 1);
        flag_clr = 3'b100;
        tick(1);
        flag_clr = 3'b000;
        chk("pwm1_meas_clr", int'(flag[2]), 0);

        // Continuous measurement: the next cycle updates without re-arming.
        wait_cnt(pre(8'h60)); drive_level(1'b0);
        wait_cnt(pre(8'h90)); drive_level(1'b1);
        wait_cnt(8'h91);
        chk("pwm2_period", int'(period), 8'h40);
        chk("pwm2_high_time", int'(high_time), 8'h10);
        chk("pwm2_meas_flag", int'(flag[2]), 1);
        flag_clr = 3'b100;
        tick(1);
        flag_clr = 3'b000;

        // Abort in HIGH: no result while disabled, and re-arm is required.
        pwm_mode = 1'b0;
        wait_cnt(pre(8'hB0)); drive_level(1'b0);
        wait_cnt(pre(8'hD0)); drive_level(1'b1);
        wait_cnt(8'hD2);
        chk("abort_period", int'(period), 8'h40);
        chk("abort_high_time", int'(high_time), 8'h10);
        chk("abort_meas_flag", int'(flag[2]), 0);
        wait_cnt(8'hD8);
        pwm_mode = 1'b1;
        wait_cnt(pre(8'hF0)); drive_level(1'b0);
        wait_cnt(pre(8'h10)); drive_level(1'b1);
        wait_cnt(8'h12);
        chk("rearm_meas_flag", int'(flag[2]), 0);
        chk("rearm_period", int'(period), 8'h40);
        wait_cnt(pre(8'h30)); drive_level(1'b0);
        wait_cnt(pre(8'h60)); drive_level(1'b1);
        wait_cnt(8'h61);
        chk("rearm_period_new", int'(period), 8'h50);
        chk("rearm_high_time_new", int'(high_time), 8'h20);
        chk("rearm_meas_flag_new", int'(flag[2]), 1);

`ifdef CAPTURE_FILTER_EN
        // Filter: a 3-cycle glitch is dropped, a 6-cycle pulse is captured.
        pwm_mode = 1'b0;
        tick(4);
        timer_in = 1'b0;
        tick(3);
        timer_in = 1'b1;
        tick(15);
        chk("glitch_cap_fall", int'(cap_fall), 8'h30);
        chk("glitch_sb_empty", sb_q.size(), 0);
        drive_level(1'b0);
        tick(6);
        drive_level(1'b1);
        tick(LAT + 3);
        chk("pulse_sb_empty", sb_q.size(), 0);
`endif

        tick(LAT + 3);
        chk("sb_empty_end", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
